// File: rtl/iob_sync_fifo.sv
// -----------------------------------------------------------------------------
// iob_sync_fifo
//
// Single-clock synchronous FIFO holding DATA_WIDTH-bit words, depth
// 2**ADDRESS_WIDTH. Occupancy is tracked in a dedicated counter. Full and empty
// are decoded from that counter, so the two flags can never both be high.
//
// The read path is chosen at elaboration time:
//   USE_RAM = 0 : first-word fall-through. data_out shows the head entry
//                 combinationally, before read_en is asserted.
//   USE_RAM = 1 : registered read. data_out is loaded from the head entry on an
//                 accepted read and is valid after that edge. It holds otherwise.
//
// Ports
//   clk            in   system clock, rising-edge active
//   rst            in   asynchronous, active-high reset
//   data_in        in   write data (DATA_WIDTH)
//   write_en       in   write request; dropped while full
//   read_en        in   read request; ignored while empty
//   data_out       out  read data (DATA_WIDTH)
//   empty          out  occupancy == 0
//   full           out  occupancy == 2**ADDRESS_WIDTH
//   fifo_ocupancy  out  stored word count, 0..2**ADDRESS_WIDTH (ADDRESS_WIDTH+1)
// -----------------------------------------------------------------------------
module iob_sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int USE_RAM       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   write_en,
  input  logic                   read_en,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   empty,
  output logic                   full,
  output logic [ADDRESS_WIDTH:0] fifo_ocupancy
);

  localparam int                   DEPTH     = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0]   CNT_FULL  = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE   = (ADDRESS_WIDTH)'(1);

  // Storage is not reset. Contents after reset are simply unreachable.
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH:0]   count;

  logic                     write_ok;
  logic                     read_ok;
  logic [DATA_WIDTH-1:0]    head_word;
  logic [DATA_WIDTH-1:0]    rd_data;

  // Flags come straight from the registered count. Both accept terms therefore
  // use the pre-edge flags. When full with both requests, only the read goes
  // through. When empty with both requests, only the write goes through.
  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign write_ok = write_en & ~full;
  assign read_ok  = read_en  & ~empty;

  assign fifo_ocupancy = count;
  assign head_word     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (write_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally at 2**ADDRESS_WIDTH through their bit width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (write_ok) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (read_ok) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({write_ok, read_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  generate
    if (USE_RAM == 0) begin : g_fwft
      // The head entry is visible as soon as it is written. Its value while
      // empty is meaningless.
      assign rd_data = head_word;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
        end else if (read_ok) begin
          dout_q <= head_word;
        end
      end

      assign rd_data = dout_q;
    end
  endgenerate

  assign data_out = rd_data;

endmodule

// File: tb/tb_iob_sync_fifo.sv
module tb_iob_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          write_en;
  logic          read_en;

  logic [DW-1:0] dout0, dout1;
  logic          empty0, empty1, full0, full1;
  logic [AW:0]   occ0, occ1;

  iob_sync_fifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .USE_RAM(0)) dut_fwft (
    .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en),
    .read_en(read_en), .data_out(dout0), .empty(empty0), .full(full0),
    .fifo_ocupancy(occ0)
  );

  iob_sync_fifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .USE_RAM(1)) dut_ram (
    .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en),
    .read_en(read_en), .data_out(dout1), .empty(empty1), .full(full1),
    .fifo_ocupancy(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. The queue holds the stored words in arrival order.
  // exp_ram is the last word popped, or 0 after reset.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_ram;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("occ_fwft",   occ0,   q.size());
    chk("occ_ram",    occ1,   q.size());
    chk("empty_fwft", empty0, q.size() == 0);
    chk("empty_ram",  empty1, q.size() == 0);
    chk("full_fwft",  full0,  q.size() == DEPTH);
    chk("full_ram",   full1,  q.size() == DEPTH);
    chk("dout_ram",   dout1,  exp_ram);
  endtask

  // Drives one clock's worth of requests. Inputs change away from the edge.
  // The edge is applied, then the model is updated and compared.
  task automatic cycle(input logic we, input logic re, input logic [DW-1:0] din);
    logic          wacc, racc;
    logic [DW-1:0] head;
    write_en = we;
    read_en  = re;
    data_in  = din;
    wacc = we && (q.size() < DEPTH);
    racc = re && (q.size() != 0);
    #1;
    if (q.size() != 0) chk("fwft_head_pre", dout0, q[0]);
    chk("ram_hold_pre", dout1, exp_ram);
    @(posedge clk);
    #1;
    if (racc) begin
      head    = q.pop_front();
      exp_ram = head;
    end
    if (wacc) q.push_back(din);
    check_state();
  endtask

  // Reset is asserted between edges and held across one rising edge, with
  // requests active, then released between edges.
  task automatic do_reset();
    write_en = 1'b1;
    read_en  = 1'b1;
    data_in  = 8'hAA;
    #2;
    rst = 1'b1;
    q.delete();
    exp_ram = '0;
    #1;
    check_state();
    @(posedge clk);
    #1;
    check_state();
    #2;
    rst = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    #1;
    check_state();
  endtask

  int mode;

  initial begin
    rst      = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = '0;
    exp_ram  = '0;
    #2;
    check_state();
    @(negedge clk);
    rst = 1'b0;

    // Fill with 32..47, then one dropped write of 47.
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, (i < 16) ? DW'(32 + i) : 8'd47);
    // Drain all 16 words.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
    // Underflow attempts.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 8'h55);
    cycle(1'b0, 1'b1, 8'h00);
    chk("ram_0x55", dout1, 8'h55);

    // Reset while full, then a short write/read sequence.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'($urandom));
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(8'hC0 + i));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);

    // Concurrent traffic at occupancy 8, which wraps the pointers.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, DW'($urandom));
    // Concurrent requests while full: only the read is taken.
    while (q.size() < DEPTH) cycle(1'b1, 1'b0, DW'($urandom));
    cycle(1'b1, 1'b1, 8'h99);
    chk("full_both_occ", occ0, 15);
    // Concurrent requests while empty: only the write is taken.
    while (q.size() > 0) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'h77);
    chk("empty_both_occ", occ0, 1);

    // Random traffic with biased phases so full and empty are both visited.
    mode = 0;
    for (int i = 0; i < 600; i++) begin
      if ((i % 40) == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 199) == 0) do_reset();
      case (mode)
        0: cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, DW'($urandom));
        1: cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 8, DW'($urandom));
        default: cycle(1'($urandom), 1'($urandom), DW'($urandom));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_sync_fifo.md
Name: iob_sync_fifo

Overview:
Single-clock synchronous FIFO buffering DATA_WIDTH-bit words with depth 2**ADDRESS_WIDTH.
It provides full/empty flags and an occupancy count.
The read path is selectable: combinational first-word-fall-through (register storage) or one-cycle registered read (RAM-style storage).
It is a generic buffer between producer and consumer logic in one clock domain.

Parameters:
DATA_WIDTH, 8, word width in bits.
ADDRESS_WIDTH, 4, pointer width; depth = 2**ADDRESS_WIDTH (16 by default).
USE_RAM, 0, selects the read path. 0 = data_out is combinational from the head entry. 1 = data_out is registered, valid one cycle after an accepted read.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
data_in  in  DATA_WIDTH  write data.
write_en  in  1  write request, sampled on rising clk.
read_en  in  1  read request, sampled on rising clk.
data_out  out  DATA_WIDTH  read data.
empty  out  1  high when occupancy == 0.
full  out  1  high when occupancy == 2**ADDRESS_WIDTH.
fifo_ocupancy  out  ADDRESS_WIDTH+1  number of stored words, 0..2**ADDRESS_WIDTH; zero-extend externally if wider.

Behaviour:
- Reset is asynchronous and active-high; it takes effect immediately, independent of clk.
  - While rst=1: read pointer, write pointer and occupancy = 0; empty=1; full=0.
  - In USE_RAM=1 mode, the data_out register is also reset to 0.
  - Storage contents are not cleared.
- Reset mid-operation discards all stored data; the FIFO is empty on the first clock after rst deasserts.
- Write accepted = write_en & ~full, evaluated before the edge.
  - An accepted write stores data_in at the write pointer; the write pointer increments modulo 2**ADDRESS_WIDTH.
  - A write while full is silently dropped: no state change, stored data is not overwritten.
- Read accepted = read_en & ~empty, evaluated before the edge.
  - The read pointer increments modulo 2**ADDRESS_WIDTH.
  - A read while empty is ignored: no pointer change, occupancy stays 0.
- Occupancy update per edge:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both or neither are accepted.
- Simultaneous read and write:
  - When full: the read is accepted, the write is rejected (full is evaluated pre-edge); occupancy becomes 2**AW-1.
  - When empty: the write is accepted, the read is rejected; occupancy becomes 1.
  - Otherwise both are accepted and occupancy is unchanged.
- full and empty are decoded from occupancy (combinational from registered state). They are never both 1.
- USE_RAM=0 (first-word fall-through):
  - data_out = mem[read pointer] combinationally, so the oldest word is visible before read_en is asserted.
  - After an accepted read, the next word appears after that edge.
  - When empty, data_out is don't-care.
- USE_RAM=1 (registered read):
  - On an accepted read, data_out <= mem[read pointer] at that edge; the value is valid after the edge.
  - Otherwise data_out holds its value.
  - First-data latency is one cycle after read_en is asserted.
- Pointer wrap-around: after 2**ADDRESS_WIDTH writes the write pointer returns to 0; order is preserved across the wrap.
- Target RTL size: 120-400 lines. The storage array is a plain reg array; the two read modes use a generate branch.

Test Plan:
1. Fill: after reset, hold write_en=1 for 17 edges with data_in=32..47, the 17th edge still carrying 47 -> full=1, fifo_ocupancy=16, empty=0; the 17th write is dropped.
2. Drain, USE_RAM=0: assert read_en -> data_out=32 before the first edge, then 33..47 after successive edges; 16 reads in total.
3. Drain, USE_RAM=1: assert read_en -> data_out=32 after the first edge, then 33..47 on the following edges.
4. Underflow: after draining, hold read_en for extra edges -> empty=1, fifo_ocupancy=0, no pointer movement. A subsequent write+read of 0x55 returns 0x55.
5. Reset while full: fill with 16 words, pulse rst for one cycle -> empty=1, full=0, fifo_ocupancy=0. Then write 3 words -> occupancy=3, read order correct. Also assert rst away from any clk edge and check flags clear immediately.
6. Concurrent traffic: with 8 stored words, hold read_en=write_en=1 for 20 edges -> occupancy stays 8 and output order matches input order across pointer wrap. At full with both asserted -> occupancy becomes 15.
